// File: rtl/img_pkg.sv
// img_pkg: shared FSM states, default frame size, plane offsets and RGB triple
package img_pkg;
    localparam int ROWS_DEF = 1153;
    localparam int COLS_DEF = 2048;
    typedef enum logic [2:0] {IDLE, RD_R, RD_G, RD_B, LAST, PRESENT, DONE} state_t;
    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;
    function automatic longint plane_offset(input int plane, input int rows, input int cols);
        return longint'(plane) * longint'(rows) * longint'(cols);
    endfunction
endpackage

// File: rtl/planar_rgb_reader_if.sv
// planar_rgb_reader_if: frame-buffer read port plus pixel stream
interface planar_rgb_reader_if #(
    parameter int ADDR_W = 23,
    parameter int IDX_W  = 22
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_red;
    logic [7:0]        pix_green;
    logic [7:0]        pix_blue;
    logic [IDX_W-1:0]  pix_index;
    modport master (
        output mem_rd, mem_addr, pix_valid, pix_red, pix_green, pix_blue, pix_index,
        input  mem_rdata, pix_ready
    );
    modport slave (
        input  mem_rd, mem_addr, pix_valid, pix_red, pix_green, pix_blue, pix_index,
        output mem_rdata, pix_ready
    );
endinterface

// File: rtl/rgb_plane_addr_gen.sv
// rgb_plane_addr_gen: pixel index counter and per-plane byte address register
module rgb_plane_addr_gen
    import img_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int ADDR_W = 23,
    parameter int IDX_W  = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic              i_ld,
    input  logic [1:0]        i_plane,
    output logic [IDX_W-1:0]  o_idx,
    output logic [ADDR_W-1:0] o_addr
);
    localparam logic [ADDR_W-1:0] OFF_G = ADDR_W'(plane_offset(1, ROWS, COLS));
    localparam logic [ADDR_W-1:0] OFF_B = ADDR_W'(plane_offset(2, ROWS, COLS));
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [ADDR_W-1:0] w_off;
    assign w_idx_nxt = i_clr ? '0 : i_inc ? r_idx + IDX_W'(1) : r_idx;
    assign w_off     = i_plane == 2'd1 ? OFF_G : i_plane == 2'd2 ? OFF_B : '0;
    // address is loaded on entry to each read state so it is valid for that whole cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_addr <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            if (i_ld) r_addr <= ADDR_W'(w_idx_nxt) + w_off;
        end
    end
    assign o_idx  = r_idx;
    assign o_addr = r_addr;
endmodule

// File: rtl/planar_rgb_reader.sv
// planar_rgb_reader: fetches R, G, B planes per pixel and streams the triples
module planar_rgb_reader
    import img_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int ADDR_W = 23,
    parameter int IDX_W  = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    planar_rgb_reader_if.master bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS * COLS - 1);
    state_t            r_state;
    state_t            w_nxt;
    logic              w_clr;
    logic              w_inc;
    logic              w_ld;
    logic [1:0]        w_plane;
    logic [IDX_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_addr;
    rgb_t              r_pix;
    rgb_plane_addr_gen #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_addr (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_inc(w_inc), .i_ld(w_ld),
        .i_plane(w_plane), .o_idx(w_idx), .o_addr(w_addr)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nxt;
    end
    // next state and index counter control
    always_comb begin
        w_nxt = r_state;
        w_clr = 1'b0;
        w_inc = 1'b0;
        case (r_state)
            IDLE:    if (start) begin
                         w_nxt = RD_R;
                         w_clr = 1'b1;
                     end
            RD_R:    w_nxt = RD_G;
            RD_G:    w_nxt = RD_B;
            RD_B:    w_nxt = LAST;
            LAST:    w_nxt = PRESENT;
            PRESENT: if (bus.pix_ready) begin
                         w_nxt = w_idx == LAST_IDX ? DONE : RD_R;
                         w_inc = w_idx != LAST_IDX;
                     end
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end
    assign w_ld    = w_nxt inside {RD_R, RD_G, RD_B};
    assign w_plane = w_nxt == RD_G ? 2'd1 : w_nxt == RD_B ? 2'd2 : 2'd0;
    // each byte arrives one cycle after its read, so capture lags the read state by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix <= '0;
        end else begin
            if (r_state == RD_G) r_pix.red   <= bus.mem_rdata;
            if (r_state == RD_B) r_pix.green <= bus.mem_rdata;
            if (r_state == LAST) r_pix.blue  <= bus.mem_rdata;
        end
    end
    assign bus.mem_rd    = r_state inside {RD_R, RD_G, RD_B};
    assign bus.mem_addr  = w_addr;
    assign bus.pix_valid = r_state == PRESENT;
    assign bus.pix_red   = r_pix.red;
    assign bus.pix_green = r_pix.green;
    assign bus.pix_blue  = r_pix.blue;
    assign bus.pix_index = w_idx;
    assign busy          = r_state != IDLE;
    assign done          = r_state == DONE;
endmodule

// File: tb/tb_planar_rgb_reader.sv
// tb_planar_rgb_reader: directed and random frames against a plane-indexing model
module tb_planar_rgb_reader;
    localparam int NA = 6;
    logic clk, rst_n, start_a, start_b, busy_a, busy_b, done_a, done_b;
    logic [7:0] mem_a [0:3*NA-1];
    logic [7:0] mem_b [0:2];
    int n_cmp, n_err, done_a_n;
    int rd_q[$];
    planar_rgb_reader_if #(.ADDR_W(8), .IDX_W(4)) ifa ();
    planar_rgb_reader_if #(.ADDR_W(8), .IDX_W(4)) ifb ();
    planar_rgb_reader #(.ROWS(2), .COLS(3), .ADDR_W(8), .IDX_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(ifa));
    planar_rgb_reader #(.ROWS(1), .COLS(1), .ADDR_W(8), .IDX_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(ifb));
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (ifa.mem_rd) begin
            ifa.mem_rdata <= mem_a[int'(ifa.mem_addr)];
            rd_q.push_back(int'(ifa.mem_addr));
        end
        if (ifb.mem_rd) ifb.mem_rdata <= mem_b[int'(ifb.mem_addr)];
        if (done_a) done_a_n <= done_a_n + 1;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [23:0] exp_pix(input int p);
        return {mem_a[p], mem_a[NA+p], mem_a[2*NA+p]};
    endfunction
    task automatic frame_a(input int stall_at, input int stall_len, input bit pokes,
                           input bit rnd, input int abort_at, input bit b2b);
        int cnt, d0, len;
        bit stall;
        d0 = done_a_n;
        rd_q.delete();
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        for (int p = 0; p < NA; p++) begin
            if (p == abort_at) begin
                @(negedge clk);
                chk("abort_rd", {ifa.mem_rd, ifa.mem_addr}, {1'b1, 8'(NA+p)});
                #2 rst_n = 0;
                #1;
                chk("rst_async", {busy_a, done_a, ifa.mem_rd, ifa.mem_addr, ifa.pix_valid,
                    ifa.pix_red, ifa.pix_green, ifa.pix_blue, ifa.pix_index}, '0);
                @(negedge clk);
                rst_n = 1;
                @(negedge clk);
                chk("rst_idle", {busy_a, ifa.pix_valid, ifa.mem_rd}, '0);
                return;
            end
            stall = rnd ? 1'($urandom_range(0, 1)) : p == stall_at;
            len = rnd ? int'($urandom_range(1, 4)) : stall_len;
            ifa.pix_ready = !stall;
            cnt = 0;
            while (!ifa.pix_valid && cnt < 20) begin
                start_a = pokes && p == 1 && cnt == 1;
                @(negedge clk);
                cnt++;
            end
            start_a = 0;
            chk("latency", cnt, 4);
            chk("pix_data", {ifa.pix_red, ifa.pix_green, ifa.pix_blue}, exp_pix(p));
            chk("pix_index", ifa.pix_index, p);
            if (stall) begin
                for (int s = 0; s < len; s++) begin
                    start_a = pokes && s == 0;
                    @(negedge clk);
                    chk("hold", {ifa.pix_valid, ifa.mem_rd, ifa.pix_red, ifa.pix_green,
                        ifa.pix_blue, ifa.pix_index}, {1'b1, 1'b0, exp_pix(p), 4'(p)});
                end
                start_a = 0;
                ifa.pix_ready = 1;
            end
            @(negedge clk);
        end
        chk("done_pulse", {done_a, busy_a, ifa.pix_valid}, 3'b110);
        start_a = b2b;
        @(negedge clk);
        chk("idle_after", {done_a, busy_a, ifa.pix_valid}, 3'b000);
        chk("done_count", done_a_n - d0, 1);
        chk("rd_count", rd_q.size(), 3*NA);
        for (int i = 0; i < rd_q.size() && i < 3*NA; i++)
            chk("rd_addr", rd_q[i], (i % 3) * NA + i / 3);
    endtask
    initial begin
        int cnt;
        n_cmp = 0; n_err = 0; done_a_n = 0;
        rst_n = 0; start_a = 0; start_b = 0;
        ifa.pix_ready = 0; ifb.pix_ready = 0;
        for (int i = 0; i < 3*NA; i++) mem_a[i] = 8'(i + 16);
        for (int i = 0; i < 3; i++) mem_b[i] = 8'(i + 16);
        repeat (2) @(negedge clk);
        chk("reset_a", {busy_a, done_a, ifa.mem_rd, ifa.mem_addr, ifa.pix_valid,
            ifa.pix_red, ifa.pix_green, ifa.pix_blue, ifa.pix_index}, '0);
        chk("reset_b", {busy_b, done_b, ifb.mem_rd, ifb.pix_valid, ifb.pix_index}, '0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_no_start", {busy_a, ifa.mem_rd, ifa.pix_valid}, '0);
        frame_a(-1, 0, 0, 0, -1, 0);
        frame_a(2, 6, 1, 0, -1, 0);
        frame_a(-1, 0, 0, 0, 4, 0);
        frame_a(-1, 0, 0, 0, -1, 1);
        frame_a(-1, 0, 0, 0, -1, 0);
        start_b = 1;
        ifb.pix_ready = 1;
        @(negedge clk);
        start_b = 0;
        cnt = 0;
        while (!ifb.pix_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("n1_latency", cnt, 4);
        chk("n1_data", {ifb.pix_red, ifb.pix_green, ifb.pix_blue, ifb.pix_index}, {24'h101112, 4'd0});
        @(negedge clk);
        chk("n1_done", {done_b, busy_b, ifb.pix_valid}, 3'b110);
        @(negedge clk);
        chk("n1_idle", {done_b, busy_b, ifb.pix_valid}, 3'b000);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3*NA; i++) mem_a[i] = 8'($urandom);
            frame_a(-1, 0, k == 1, 1, -1, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
